// File: rtl/dac_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dac_arbiter_pkg
// Shared definitions for the DAC SPI arbiter and the blocks that talk to the
// DAC (control loop, CPU direct-write path).
//   - state_t       : arbiter FSM encoding (also exported on the debug port)
//   - DAC_CMD_*     : command nibble codes placed in the top 4 bits of a word
// -----------------------------------------------------------------------------
package dac_arbiter_pkg;

  localparam int STATE_WID = 2;

  typedef enum logic [STATE_WID-1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam logic [3:0] DAC_CMD_WRITE = 4'b0001;
  localparam logic [3:0] DAC_CMD_READ  = 4'b1001;

endpackage

// File: rtl/dac_arbiter_if.sv
// -----------------------------------------------------------------------------
// dac_arbiter_if
// Bundles the requester-side and SPI-master-side DAC handshakes.
//   req_arm/req_ss/req_lock/req_word : from requesters (word i at [i*DAC_WID +: DAC_WID])
//   req_finished/req_from_dac        : back to requesters
//   grant                            : one-hot current owner, 0 when none
//   master_arm/master_ss/master_word : to the SPI master
//   master_finished/master_from_dac  : from the SPI master
//
// Handshake: a requester raises arm (with ss and word stable) and keeps it high
// until it sees its finished bit pulse; finished is a single-cycle strobe from
// the SPI master routed only to the owner. Dropping arm before finished is an
// abort; the arbiter then keeps the master armed until it reports finished.
//
// Modports: slave = arbiter view, master = requesters + SPI master environment.
// -----------------------------------------------------------------------------
interface dac_arbiter_if #(
  parameter int N_REQ   = 3,
  parameter int DAC_WID = 24
);
  logic [N_REQ-1:0]         req_arm;
  logic [N_REQ-1:0]         req_ss;
  logic [N_REQ-1:0]         req_lock;
  logic [N_REQ*DAC_WID-1:0] req_word;
  logic [N_REQ-1:0]         req_finished;
  logic [DAC_WID-1:0]       req_from_dac;
  logic [N_REQ-1:0]         grant;
  logic                     master_arm;
  logic                     master_ss;
  logic [DAC_WID-1:0]       master_word;
  logic                     master_finished;
  logic [DAC_WID-1:0]       master_from_dac;

  modport slave (
    input  req_arm, req_ss, req_lock, req_word, master_finished, master_from_dac,
    output req_finished, req_from_dac, grant, master_arm, master_ss, master_word
  );

  modport master (
    output req_arm, req_ss, req_lock, req_word, master_finished, master_from_dac,
    input  req_finished, req_from_dac, grant, master_arm, master_ss, master_word
  );
endinterface

// File: rtl/dac_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first set bit of i_req
// searching upward from index i_ptr and wrapping modulo N.
//   i_req   : request vector
//   i_ptr   : index with highest priority this evaluation (< N)
//   o_valid : any request set
//   o_sel   : selected index (0 when !o_valid)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter  int N       = 3,
  localparam int PTR_WID = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       i_req,
  input  logic [PTR_WID-1:0] i_ptr,
  output logic               o_valid,
  output logic [PTR_WID-1:0] o_sel
);

  int w_idx;

  always_comb begin
    o_valid = 1'b0;
    o_sel   = '0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      // i_ptr < N and i < N, so one subtraction is enough to wrap.
      w_idx = int'(i_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_sel   = PTR_WID'(w_idx);
      end
    end
  end

endmodule

// File: rtl/dac_arbiter.sv
// -----------------------------------------------------------------------------
// dac_arbiter
// Shares one DAC SPI master between N_REQ requesters. Round-robin grant, grant
// held while the owner asserts req_lock, abort drain, and a GAP_CYCLES
// chip-select-low gap between owners.
//   clk, rst    : clock, asynchronous active-high reset
//   io_bus      : dac_arbiter_if slave (requester and SPI master handshakes)
//   o_state     : debug, current FSM state
//   o_rr_ptr    : debug, round-robin pointer (highest priority index next)
// -----------------------------------------------------------------------------
module dac_arbiter
  import dac_arbiter_pkg::*;
#(
  parameter  int N_REQ      = 3,
  parameter  int DAC_WID    = 24,
  parameter  int GAP_CYCLES = 4,
  parameter  int GAP_WID    = 4,
  localparam int PTR_WID    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  dac_arbiter_if.slave       io_bus,
  output state_t             o_state,
  output logic [PTR_WID-1:0] o_rr_ptr
);

  localparam logic [GAP_WID-1:0] GAP_LAST = GAP_WID'(GAP_CYCLES - 1);
  localparam logic [PTR_WID-1:0] PTR_LAST = PTR_WID'(N_REQ - 1);

  state_t               r_state,     w_state_nxt;
  logic [N_REQ-1:0]     r_grant,     w_grant_nxt;
  logic [PTR_WID-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [GAP_WID-1:0]   r_gap_cnt,   w_gap_cnt_nxt;
  logic                 r_fin_seen,  w_fin_seen_nxt;
  logic                 r_arm_prev,  w_arm_prev_nxt;
  logic [DAC_WID-1:0]   r_word_hold, w_word_hold_nxt;

  logic                 w_pick_valid;
  logic [PTR_WID-1:0]   w_pick_sel;
  logic [N_REQ-1:0]     w_pick_onehot;
  logic                 w_own_arm;
  logic                 w_own_ss;
  logic                 w_own_lock;
  logic [DAC_WID-1:0]   w_own_word;
  logic                 w_fin_any;

  rr_picker #(.N(N_REQ)) u_picker (
    .i_req   (io_bus.req_arm),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_sel   (w_pick_sel)
  );

  assign w_pick_onehot = N_REQ'(1) << w_pick_sel;

  // Owner's signals; a non-owner's ss/word/lock never reach the master.
  assign w_own_arm  = |(io_bus.req_arm  & r_grant);
  assign w_own_ss   = |(io_bus.req_ss   & r_grant);
  assign w_own_lock = |(io_bus.req_lock & r_grant);

  always_comb begin
    w_own_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_own_word = w_own_word | io_bus.req_word[i*DAC_WID +: DAC_WID];
    end
  end

  // Finished seen for the owner's current arm pulse, including this cycle.
  assign w_fin_any = r_fin_seen | io_bus.master_finished;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_fin_seen  <= 1'b0;
      r_arm_prev  <= 1'b0;
      r_word_hold <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_fin_seen  <= w_fin_seen_nxt;
      r_arm_prev  <= w_arm_prev_nxt;
      r_word_hold <= w_word_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_fin_seen_nxt  = r_fin_seen;
    w_arm_prev_nxt  = r_arm_prev;
    w_word_hold_nxt = r_word_hold;

    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt    = w_pick_onehot;
          w_rr_ptr_nxt   = (w_pick_sel == PTR_LAST) ? '0 : w_pick_sel + 1'b1;
          w_fin_seen_nxt = 1'b0;
          w_arm_prev_nxt = 1'b1;
          w_state_nxt    = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        w_word_hold_nxt = w_own_word;
        w_arm_prev_nxt  = w_own_arm;
        // A fresh arm pulse (locked sequence) restarts finished tracking.
        if (w_own_arm && !r_arm_prev) w_fin_seen_nxt = io_bus.master_finished;
        else                          w_fin_seen_nxt = w_fin_any;

        if (!w_own_arm) begin
          if (!w_fin_any) begin
            w_state_nxt = S_DRAIN;
          end else if (!w_own_lock) begin
            w_state_nxt   = S_GAP;
            w_grant_nxt   = '0;
            w_gap_cnt_nxt = '0;
          end
        end
      end

      S_DRAIN: begin
        if (io_bus.master_finished) begin
          w_state_nxt   = S_GAP;
          w_grant_nxt   = '0;
          w_gap_cnt_nxt = '0;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = S_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Master side: live mux in ACTIVE, forced armed with frozen word in DRAIN,
  // quiet otherwise so reset/GAP drop arm and ss immediately.
  always_comb begin
    io_bus.master_arm  = 1'b0;
    io_bus.master_ss   = 1'b0;
    io_bus.master_word = '0;
    case (r_state)
      S_ACTIVE: begin
        io_bus.master_arm  = w_own_arm;
        io_bus.master_ss   = w_own_ss;
        io_bus.master_word = w_own_word;
      end
      S_DRAIN: begin
        io_bus.master_arm  = 1'b1;
        io_bus.master_ss   = 1'b1;
        io_bus.master_word = r_word_hold;
      end
      default: ;
    endcase
  end

  assign io_bus.grant        = r_grant;
  assign io_bus.req_finished = r_grant & {N_REQ{io_bus.master_finished}};
  assign io_bus.req_from_dac = io_bus.master_from_dac;

  assign o_state  = r_state;
  assign o_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_dac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dac_arbiter
// Directed bench for dac_arbiter (N_REQ=3, DAC_WID=24, GAP_CYCLES=4).
// Inputs are driven and outputs observed 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_dac_arbiter;
  import dac_arbiter_pkg::*;

  localparam int N = 3;
  localparam int W = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_arbiter_if #(.N_REQ(N), .DAC_WID(W)) bus ();

  state_t     dbg_state;
  logic [1:0] dbg_ptr;

  dac_arbiter #(
    .N_REQ(N), .DAC_WID(W), .GAP_CYCLES(4), .GAP_WID(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .io_bus   (bus),
    .o_state  (dbg_state),
    .o_rr_ptr (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [W-1:0] words[N] = '{24'h100A01, 24'h100B02, 24'h100C03};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic arm, input logic ss, input logic [W-1:0] word);
    bus.req_arm[i]            = arm;
    bus.req_ss[i]             = ss;
    bus.req_word[i*W +: W]    = word;
  endtask

  task automatic pulse_finished(input string tag, input logic [W-1:0] rd, input logic [N-1:0] exp_fin);
    bus.master_from_dac = rd;
    bus.master_finished = 1'b1;
    #1;
    check_eq({tag, "_fin"}, 32'(bus.req_finished), 32'(exp_fin));
    check_eq({tag, "_rd"},  32'(bus.req_from_dac), 32'(rd));
    step(1);
    bus.master_finished = 1'b0;
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output int zeros, output int gaps);
    g = '0; zeros = 0; gaps = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (bus.grant != '0) begin
        g = bus.grant;
        break;
      end
      zeros++;
      if (dbg_state == S_GAP) gaps++;
    end
    check_eq("grant_seen", 32'(g != '0), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      if (dbg_state == S_IDLE) break;
      step(1);
    end
    check_eq("idle_reached", 32'(dbg_state), 32'(S_IDLE));
  endtask

  function automatic int idx_of(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] g, e;
    int z, gp, ss_low;

    bus.req_arm = '0; bus.req_ss = '0; bus.req_lock = '0; bus.req_word = '0;
    bus.master_finished = 1'b0; bus.master_from_dac = '0;

    // Reset state
    step(2);
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_arm",   32'(bus.master_arm), 32'd0);
    check_eq("rst_ss",    32'(bus.master_ss), 32'd0);
    check_eq("rst_word",  32'(bus.master_word), 32'd0);
    check_eq("rst_fin",   32'(bus.req_finished), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("rst_ptr",   32'(dbg_ptr), 32'd0);
    rst = 1'b0;
    step(1);

    // 1) Single requester
    set_req(1, 1'b1, 1'b1, 24'h1ABCDE);
    #1;
    check_eq("t1_no_grant_yet", 32'(bus.grant), 32'd0);
    step(1);
    check_eq("t1_grant", 32'(bus.grant), 32'b010);
    check_eq("t1_arm",   32'(bus.master_arm), 32'd1);
    check_eq("t1_ss",    32'(bus.master_ss), 32'd1);
    check_eq("t1_word",  32'(bus.master_word), 32'h1ABCDE);
    check_eq("t1_ptr",   32'(dbg_ptr), 32'd2);
    pulse_finished("t1", 24'h000123, 3'b010);
    set_req(1, 1'b0, 1'b0, 24'h1ABCDE);
    gp = 0; ss_low = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (dbg_state == S_GAP) begin
        gp++;
        if (!bus.master_ss && bus.grant == '0) ss_low++;
      end
    end
    check_eq("t1_gap_cycles", 32'(gp), 32'd4);
    check_eq("t1_gap_ss_low", 32'(ss_low), 32'd4);
    check_eq("t1_back_idle",  32'(dbg_state), 32'(S_IDLE));

    // 2) Three simultaneous requests from reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t2_ptr_reset", 32'(dbg_ptr), 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, words[i]);
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    for (int n = 0; n < 4; n++) begin
      wait_grant(g, z, gp);
      e = exp_q.pop_front();
      check_eq("t2_grant_order", 32'(g), 32'(e));
      check_eq("t2_word", 32'(bus.master_word), 32'(words[idx_of(e)]));
      if (n > 0) begin
        check_eq("t2_idle_between", 32'(z), 32'd5);
        check_eq("t2_gap_between",  32'(gp), 32'd4);
      end
      pulse_finished("t2", 24'h0, e);
      set_req(idx_of(e), 1'b0, 1'b0, words[idx_of(e)]);
      if (n == 2) set_req(0, 1'b1, 1'b1, words[0]);
    end
    wait_idle();

    // 3) Locked read sequence on requester 0, requester 2 waiting
    bus.req_lock[0] = 1'b1;
    set_req(0, 1'b1, 1'b1, 24'h900000);
    step(1);
    check_eq("t3_grant",  32'(bus.grant), 32'b001);
    check_eq("t3_word1",  32'(bus.master_word), 32'h900000);
    set_req(2, 1'b1, 1'b1, 24'h1C0C0C);
    pulse_finished("t3_1", 24'h000011, 3'b001);
    set_req(0, 1'b0, 1'b0, 24'h900000);
    step(3);
    check_eq("t3_hold_grant", 32'(bus.grant), 32'b001);
    check_eq("t3_hold_arm",   32'(bus.master_arm), 32'd0);
    check_eq("t3_hold_state", 32'(dbg_state), 32'(S_ACTIVE));
    set_req(0, 1'b1, 1'b1, 24'h000000);
    step(1);
    check_eq("t3_grant2", 32'(bus.grant), 32'b001);
    check_eq("t3_arm2",   32'(bus.master_arm), 32'd1);
    check_eq("t3_word2",  32'(bus.master_word), 32'h000000);
    pulse_finished("t3_2", 24'h0F00AA, 3'b001);
    set_req(0, 1'b0, 1'b0, 24'h0);
    bus.req_lock[0] = 1'b0;
    wait_grant(g, z, gp);
    check_eq("t3_next_owner", 32'(g), 32'b100);
    check_eq("t3_idle_between", 32'(z), 32'd5);
    check_eq("t3_gap_between",  32'(gp), 32'd4);
    pulse_finished("t3_3", 24'h0, 3'b100);
    set_req(2, 1'b0, 1'b0, 24'h1C0C0C);
    wait_idle();

    // 4) Abort: owner drops arm two cycles after grant
    set_req(1, 1'b1, 1'b1, 24'h155555);
    step(1);
    check_eq("t4_grant", 32'(bus.grant), 32'b010);
    step(1);
    set_req(0, 1'b1, 1'b1, words[0]);
    step(1);
    set_req(1, 1'b0, 1'b0, 24'h155555);
    step(1);
    check_eq("t4_state_drain", 32'(dbg_state), 32'(S_DRAIN));
    set_req(1, 1'b0, 1'b0, 24'h0BAD00);
    #1;
    check_eq("t4_arm_held",  32'(bus.master_arm), 32'd1);
    check_eq("t4_ss_held",   32'(bus.master_ss), 32'd1);
    check_eq("t4_word_frozen", 32'(bus.master_word), 32'h155555);
    step(3);
    check_eq("t4_arm_still", 32'(bus.master_arm), 32'd1);
    check_eq("t4_no_steal",  32'(bus.grant), 32'b010);
    pulse_finished("t4", 24'h0, 3'b010);
    check_eq("t4_gap_state", 32'(dbg_state), 32'(S_GAP));
    check_eq("t4_gap_arm",   32'(bus.master_arm), 32'd0);
    check_eq("t4_gap_grant", 32'(bus.grant), 32'd0);
    wait_grant(g, z, gp);
    check_eq("t4_next_owner", 32'(g), 32'b001);

    // 5) Asynchronous reset mid-transfer
    check_eq("t5_pre_arm", 32'(bus.master_arm), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_arm",   32'(bus.master_arm), 32'd0);
    check_eq("t5_async_ss",    32'(bus.master_ss), 32'd0);
    check_eq("t5_async_grant", 32'(bus.grant), 32'd0);
    check_eq("t5_async_state", 32'(dbg_state), 32'(S_IDLE));
    set_req(1, 1'b1, 1'b1, words[1]);
    set_req(2, 1'b1, 1'b1, words[2]);
    step(1);
    rst = 1'b0;
    step(1);
    check_eq("t5_first_after_rst", 32'(bus.grant), 32'b001);
    pulse_finished("t5", 24'h0, 3'b001);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, words[i]);
    wait_idle();

    // 6) Lock without arm is ignored; pointer wrap
    bus.req_lock[2] = 1'b1;
    step(3);
    check_eq("t6_lock_no_arm", 32'(bus.grant), 32'd0);
    bus.req_lock[2] = 1'b0;
    set_req(1, 1'b1, 1'b1, words[1]);
    step(1);
    check_eq("t6_grant1", 32'(bus.grant), 32'b010);
    pulse_finished("t6_1", 24'h0, 3'b010);
    set_req(1, 1'b0, 1'b0, words[1]);
    wait_idle();
    check_eq("t6_ptr2", 32'(dbg_ptr), 32'd2);
    set_req(0, 1'b1, 1'b1, words[0]);
    set_req(1, 1'b1, 1'b1, words[1]);
    step(1);
    check_eq("t6_wrap", 32'(bus.grant), 32'b001);
    pulse_finished("t6_2", 24'h0, 3'b001);
    set_req(0, 1'b0, 1'b0, words[0]);
    set_req(1, 1'b0, 1'b0, words[1]);
    step(2);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
